// File: rtl/gaussian_blur_stream.sv
// Streaming separable binomial KSIZE x KSIZE blur over a valid/ready raster stream.
// Optional GAUSS_BYPASS_EN adds a 'bypass' input that passes the window-centre pixel through.
module gaussian_blur_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned KSIZE = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
`ifdef GAUSS_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_eol
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = $clog2(KSIZE);
  localparam int unsigned VW = PIX_W + KSIZE - 1;
  localparam int unsigned HW = PIX_W + 2 * (KSIZE - 1);
  localparam int unsigned S  = 2 * (KSIZE - 1);

  // Binomial coefficient C(n, k); loop bounded by KSIZE so it unrolls statically.
  function automatic int unsigned binom(input int unsigned n, input int unsigned k);
    int unsigned c;
    c = 1;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      if (i < k) c = c * (n - i) / (i + 1);
    end
    return c;
  endfunction

  logic                 w_en, w_acc, w_wrap, w_win;
  logic [CW-1:0]        w_col, r_col;
  logic [RW-1:0]        w_row, r_row;
  logic [PIX_W-1:0]     w_vpix [KSIZE];
  logic [VW-1:0]        w_vsum;
  logic [HW-1:0]        w_hsum, w_hrnd;
  logic [PIX_W-1:0]     w_filt, w_res;
  logic [PIX_W-1:0]     r_lb   [KSIZE-1][IMG_W];
  logic [VW-1:0]        r_hsr  [KSIZE];
  logic                 r_s1_valid, r_s1_eol;
  logic                 r_out_valid, r_out_eol;
  logic [PIX_W-1:0]     r_out_pix;
`ifdef GAUSS_BYPASS_EN
  localparam int unsigned R = (KSIZE - 1) / 2;
  logic [PIX_W-1:0]     r_csr  [KSIZE];
  logic                 r_s1_byp;
`endif

  always_comb begin
    w_en   = !r_out_valid || out_ready;
    w_acc  = in_valid && w_en;
    // sof restarts the frame before the pixel is stored
    w_col  = in_sof ? '0 : r_col;
    w_row  = in_sof ? '0 : r_row;
    w_wrap = (w_col == CW'(IMG_W - 1));
    w_win  = (w_row == RW'(KSIZE - 1)) && (w_col >= CW'(KSIZE - 1));

    w_vpix[0] = in_pix;
    for (int unsigned k = 1; k < KSIZE; k++) w_vpix[k] = r_lb[k-1][w_col];

    w_vsum = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      w_vsum = w_vsum + VW'(binom(KSIZE - 1, i)) * VW'(w_vpix[i]);
    end

    w_hsum = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      w_hsum = w_hsum + HW'(binom(KSIZE - 1, i)) * HW'(r_hsr[i]);
    end
    w_hrnd = w_hsum + HW'(1 << (S - 1));
    w_filt = PIX_W'(w_hrnd >> S);
`ifdef GAUSS_BYPASS_EN
    w_res  = r_s1_byp ? r_csr[R] : w_filt;
`else
    w_res  = w_filt;
`endif
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_eol   = r_out_eol;

  // Control: counters and pipeline valids.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_eol    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_pix   <= '0;
    end else if (w_en) begin
      r_s1_valid  <= w_acc && w_win;
      r_out_valid <= r_s1_valid;
      r_out_eol   <= r_s1_valid && r_s1_eol;
      if (r_s1_valid) r_out_pix <= w_res;
      if (w_acc) begin
        r_s1_eol <= w_wrap;
        r_col    <= w_wrap ? '0 : w_col + CW'(1);
        if (w_wrap && (w_row != RW'(KSIZE - 1))) r_row <= w_row + RW'(1);
        else                                     r_row <= w_row;
      end
    end
  end

  // Datapath storage: line buffers and horizontal column-sum shift register.
  always_ff @(posedge clk) begin
    if (n_rst && w_acc) begin
      r_lb[0][w_col] <= in_pix;
      for (int unsigned k = 1; k < KSIZE - 1; k++) r_lb[k][w_col] <= r_lb[k-1][w_col];
      r_hsr[0] <= w_vsum;
      for (int unsigned i = 1; i < KSIZE; i++) r_hsr[i] <= r_hsr[i-1];
`ifdef GAUSS_BYPASS_EN
      r_s1_byp <= bypass;
      r_csr[0] <= w_vpix[R];
      for (int unsigned i = 1; i < KSIZE; i++) r_csr[i] <= r_csr[i-1];
`endif
    end
  end

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Randomized bench for gaussian_blur_stream: image-coordinate reference model plus a KSIZE=5 instance.
module tb_gaussian_blur_stream;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pix = '0;
  logic       out_ready = 1'b1;
  logic       bp_g = 1'b0;
  logic       in_ready, out_valid, out_eol;
  logic [7:0] out_pix;
  logic       o5_in_ready, o5_valid, o5_eol;
  logic [7:0] o5_pix;

  always #5 clk = ~clk;

  gaussian_blur_stream #(.PIX_W(8), .IMG_W(8), .KSIZE(3)) u_dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_pix(in_pix),
`ifdef GAUSS_BYPASS_EN
    .bypass(bp_g),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_eol(out_eol)
  );

  gaussian_blur_stream #(.PIX_W(8), .IMG_W(8), .KSIZE(5)) u_dut5 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(o5_in_ready), .in_sof(in_sof),
    .in_pix(in_pix),
`ifdef GAUSS_BYPASS_EN
    .bypass(bp_g),
`endif
    .out_valid(o5_valid), .out_ready(out_ready), .out_pix(o5_pix), .out_eol(o5_eol)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int n_out = 0;
  bit last_acc;
  bit k5_on = 1'b0;
  int k5_n = 0;
  int k5_acc = 0;

  // Reference model: image history indexed by (row, col) since the last sof/reset.
  int hist [16][8];
  int mr = 0, mc = 0;
  int exp_pix [$];
  bit exp_eol [$];
  int wt [3] = '{1, 2, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_push(input int pix, input bit sof, input bit bp);
    int s;
    if (sof) begin mr = 0; mc = 0; end
    hist[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) s += wt[i] * wt[j] * hist[mr-2+i][mc-2+j];
      exp_pix.push_back(bp ? hist[mr-1][mc-1] : (s + 8) / 16);
      exp_eol.push_back(mc == 7);
    end
    mc++;
    if (mc == 8) begin mc = 0; if (mr < 15) mr++; end
  endtask

  task automatic cycle();
    out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    #1;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    last_acc = in_valid && in_ready && n_rst;
    if (n_rst && out_valid && out_ready) begin
      chk("out_expected", exp_pix.size() != 0, 1);
      if (exp_pix.size() != 0) begin
        chk("out_pix", out_pix, exp_pix.pop_front());
        chk("out_eol", out_eol, exp_eol.pop_front());
      end
      n_out++;
    end
    if (k5_on && o5_valid) begin
      chk("k5_pix", o5_pix, 255);
      if (k5_n == 0) chk("k5_latency", cyc, k5_acc + 2);
      k5_n++;
    end
    @(posedge clk);
    if (last_acc) model_push(in_pix, in_sof, bp_g);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int pix, input bit sof, input int gap_pct);
    int tries;
    in_valid = 1'b0;
    while ($urandom_range(99) < gap_pct) cycle();
    in_valid = 1'b1;
    in_pix   = pix[7:0];
    in_sof   = sof;
    tries    = 0;
    do begin cycle(); tries++; end while (!last_acc && tries < 1000);
    if (!last_acc) begin
      $display("FAIL accept_timeout observed=stalled expected=accept");
      $fatal(1, "stalled");
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  function automatic int pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (r == 2 && c == 2) ? 255 : 0;
      2:       return (r * 24 + c * 9) & 255;
      3:       return int'($urandom_range(255));
      default: return 255;
    endcase
  endfunction

  task automatic send_pixels(input int kind, input int npix, input int gap_pct);
    for (int n = 0; n < npix; n++) send(pix_of(kind, n / 8, n % 8), n == 0, gap_pct);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rdy_pct  = 100;
    repeat (8) cycle();
    chk("drain_empty", exp_pix.size(), 0);
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    n_rst    = 1'b0;
    repeat (n) cycle();
    n_rst = 1'b1;
    mr = 0;
    mc = 0;
    exp_pix.delete();
    exp_eol.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    // KSIZE=5 constant 255: no overflow, first output 2 cycles after (row4,col4) accept.
    k5_on = 1'b1;
    for (int n = 0; n < 48; n++) begin
      send(255, n == 0, 0);
      if (n == 36) k5_acc = cyc - 1;
    end
    drain();
    chk("k5_count", k5_n, 8);
    k5_on = 1'b0;

    n_out = 0;
    send_pixels(0, 48, 0);
    drain();
    chk("const100_count", n_out, 24);

    send_pixels(1, 48, 0);
    drain();

    rdy_pct = 50;
    send_pixels(2, 48, 30);
    drain();

    rdy_pct = 70;
    send_pixels(3, 48, 10);
    drain();

    // Mid-frame sof at (row3,col5): 9 old outputs then 12 from the new 4-line frame.
    n_out = 0;
    rdy_pct = 60;
    send_pixels(3, 29, 15);
    send_pixels(3, 32, 15);
    drain();
    chk("sof_count", n_out, 21);

    send_pixels(3, 28, 0);
    do_reset(1);
    rdy_pct = 60;
    send_pixels(3, 40, 20);
    drain();

`ifdef GAUSS_BYPASS_EN
    bp_g = 1'b1;
    send_pixels(1, 48, 0);
    drain();
    bp_g = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
